// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a programmed burst from a synchronous FIFO onto a valid/ready stream,
// absorbing the FIFO's one-cycle read latency with a 2-entry skid buffer.
module fifo_burst_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      burst_len,
  input  logic                  abort,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      words_sent,
  output logic                  underflow_err
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;
  state_t                state_q;
  logic [LEN_W-1:0]      len_q, issued_q, words_q;
  logic [FIFO_WIDTH-1:0] mem_q [2];
  logic [1:0]            occ_q;
  logic                  hd_q, inflight_q, uf_q;
  logic                  pop, room, last;
  // m_ready feeds rd_en combinationally so a draining skid can be refilled every cycle
  always_comb begin
    pop        = (occ_q != 2'd0) && m_ready;
    room       = ({1'b0, occ_q} + {2'b0, inflight_q}) <= (3'd1 + {2'b0, pop});
    fifo_rd_en = (state_q == S_RUN) && !abort && !fifo_empty && (issued_q < len_q) && room;
    last       = (issued_q + LEN_W'(1)) == len_q;
  end
  assign m_valid       = occ_q != 2'd0;
  assign m_data        = mem_q[hd_q];
  assign busy          = (state_q == S_RUN) || (state_q == S_WAIT);
  assign done          = state_q == S_DONE;
  assign words_sent    = words_q;
  assign underflow_err = uf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      words_q    <= '0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      occ_q      <= 2'd0;
      hd_q       <= 1'b0;
      inflight_q <= 1'b0;
      uf_q       <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
      occ_q      <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
      if (inflight_q) mem_q[hd_q ^ occ_q[0]] <= fifo_data_out;
      if (inflight_q && fifo_underflow) uf_q <= 1'b1;
      if (pop) begin
        hd_q    <= ~hd_q;
        words_q <= words_q + LEN_W'(1);
      end
      if (fifo_rd_en) issued_q <= issued_q + LEN_W'(1);
      case (state_q)
        S_IDLE: if (start) begin
          len_q    <= burst_len;
          issued_q <= '0;
          words_q  <= '0;
          uf_q     <= 1'b0;
          state_q  <= (burst_len != '0) ? S_RUN : S_DONE;
        end
        S_RUN:  if (abort || (fifo_rd_en && last)) state_q <= S_WAIT;
        S_WAIT: if (occ_q == 2'd0 && !inflight_q) state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed and randomized bursts against a queue-style FIFO model;
// the delivered stream must equal the FIFO write order, with cycle checks taken from the protocol timing.
module tb_fifo_burst_reader;
  logic        clk = 0;
  logic        rst, start, abort, m_ready;
  logic [7:0]  burst_len;
  logic        fifo_empty, fifo_underflow, fifo_rd_en;
  logic [15:0] fifo_data_out, m_data;
  logic        m_valid, busy, done, underflow_err;
  logic [7:0]  words_sent;
  logic [15:0] fmem [0:1023];
  int          wr_ptr = 0, rd_ptr = 0;
  logic        flush = 0, force_uf = 0;
  int          errors = 0, checks = 0;
  int          reads = 0, hs = 0, del_idx = 0, ready_mode = 0;
  logic        prev_stall = 0, saw_done = 0;
  logic [15:0] prev_data = '0;

  fifo_burst_reader #(.FIFO_WIDTH(16), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .abort(abort),
    .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out), .fifo_underflow(fifo_underflow),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .done(done), .words_sent(words_sent), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      if (wr_ptr == rd_ptr) fifo_underflow <= 1'b1;
      else begin
        fifo_data_out  <= fmem[rd_ptr];
        rd_ptr         <= rd_ptr + 1;
        fifo_underflow <= force_uf;
      end
    end else fifo_underflow <= 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] d);
    fmem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic sample();
    @(negedge clk);
    chk("outstanding_le_2", {31'd0, (reads - hs) <= 2}, 32'd1);
    if (fifo_rd_en) chk("rd_while_empty", {31'd0, fifo_empty}, 32'd0);
    if (prev_stall) begin
      chk("stall_valid", {31'd0, m_valid}, 32'd1);
      chk("stall_data", {16'd0, m_data}, {16'd0, prev_data});
    end
    if (m_valid && m_ready) begin
      chk("stream_data", {16'd0, m_data}, {16'd0, fmem[del_idx]});
      del_idx++;
      hs++;
    end
    if (fifo_rd_en) reads++;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    if (done) saw_done = 1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    if (ready_mode == 1) m_ready = ~m_ready;
    else if (ready_mode == 2) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    sample();
    adv();
  endtask

  task automatic run_wait();
    int n = 0;
    while (!saw_done && n < 300) begin
      tick();
      n++;
    end
    chk("done_within_budget", {31'd0, saw_done}, 32'd1);
  endtask

  task automatic begin_burst(input logic [7:0] len);
    start = 1; burst_len = len; saw_done = 0;
    sample();
    adv();
    start = 0;
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; m_ready = 1; burst_len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 0);
    chk("rst_valid", {31'd0, m_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_data", {16'd0, m_data}, 0);
    chk("rst_words", {24'd0, words_sent}, 0);
    chk("rst_uferr", {31'd0, underflow_err}, 0);
    @(posedge clk); #1 rst = 0;

    // nominal burst: exact cycle timing
    for (int i = 1; i <= 5; i++) wr(16'(i));
    begin_burst(8'd5);
    for (int c = 1; c <= 10; c++) begin
      sample();
      chk($sformatf("t1_rd_en_c%0d", c), {31'd0, fifo_rd_en}, {31'd0, c >= 1 && c <= 5});
      chk($sformatf("t1_valid_c%0d", c), {31'd0, m_valid}, {31'd0, c >= 3 && c <= 7});
      if (c >= 3 && c <= 7) chk($sformatf("t1_data_c%0d", c), {16'd0, m_data}, c - 2);
      chk($sformatf("t1_busy_c%0d", c), {31'd0, busy}, {31'd0, c >= 1 && c <= 8});
      chk($sformatf("t1_done_c%0d", c), {31'd0, done}, {31'd0, c == 9});
      adv();
    end
    chk("t1_words", {24'd0, words_sent}, 5);
    chk("t1_uferr", {31'd0, underflow_err}, 0);

    // toggling backpressure
    for (int i = 0; i < 5; i++) wr(16'($urandom));
    ready_mode = 1;
    begin_burst(8'd5);
    run_wait();
    chk("t2_words", {24'd0, words_sent}, 5);
    chk("t2_delivered", del_idx, wr_ptr);
    ready_mode = 0; m_ready = 1;

    // empty-FIFO stall then top-up
    wr(16'hA001); wr(16'hA002);
    begin_burst(8'd4);
    repeat (12) tick();
    sample();
    chk("t3_stall_rd_en", {31'd0, fifo_rd_en}, 0);
    chk("t3_stall_busy", {31'd0, busy}, 1);
    chk("t3_stall_valid", {31'd0, m_valid}, 0);
    chk("t3_stall_words", {24'd0, words_sent}, 2);
    adv();
    wr(16'hA003); wr(16'hA004);
    run_wait();
    chk("t3_words", {24'd0, words_sent}, 4);

    // abort after three reads
    for (int i = 0; i < 10; i++) wr(16'($urandom));
    begin_burst(8'd10);
    repeat (3) tick();
    abort = 1;
    sample();
    chk("t4_abort_rd_en", {31'd0, fifo_rd_en}, 0);
    adv();
    abort = 0;
    run_wait();
    chk("t4_words", {24'd0, words_sent}, 3);
    chk("t4_fifo_left", wr_ptr - rd_ptr, 7);
    ready_mode = 2;
    begin_burst(8'd7);
    run_wait();
    chk("t4_drain_words", {24'd0, words_sent}, 7);
    ready_mode = 0; m_ready = 1;

    // asynchronous reset with a full skid
    for (int i = 0; i < 5; i++) wr(16'($urandom));
    m_ready = 0;
    begin_burst(8'd5);
    repeat (3) tick();
    sample();
    chk("t5_pre_valid", {31'd0, m_valid}, 1);
    chk("t5_pre_outstanding", reads - hs, 2);
    @(posedge clk);
    #4 rst = 1;
    #1;
    chk("t5_rst_valid", {31'd0, m_valid}, 0);
    chk("t5_rst_busy", {31'd0, busy}, 0);
    chk("t5_rst_rd_en", {31'd0, fifo_rd_en}, 0);
    chk("t5_rst_data", {16'd0, m_data}, 0);
    chk("t5_rst_words", {24'd0, words_sent}, 0);
    flush = 1;
    @(posedge clk);
    #1 rst = 0; flush = 0;
    reads = 0; hs = 0; prev_stall = 0; del_idx = wr_ptr; m_ready = 1;
    wr(16'h5A5A);
    begin_burst(8'd1);
    run_wait();
    chk("t5_words", {24'd0, words_sent}, 1);

    // zero-length burst
    start = 1; burst_len = 8'd0;
    sample();
    chk("t6_c0_rd_en", {31'd0, fifo_rd_en}, 0);
    adv();
    start = 0;
    sample();
    chk("t6_c1_done", {31'd0, done}, 1);
    chk("t6_c1_rd_en", {31'd0, fifo_rd_en}, 0);
    chk("t6_c1_busy", {31'd0, busy}, 0);
    adv();
    sample();
    chk("t6_c2_done", {31'd0, done}, 0);
    adv();

    // sticky underflow, cleared by the next accepted start
    force_uf = 1;
    for (int i = 0; i < 3; i++) wr(16'($urandom));
    begin_burst(8'd3);
    run_wait();
    force_uf = 0;
    chk("t7_uferr_set", {31'd0, underflow_err}, 1);
    chk("t7_words", {24'd0, words_sent}, 3);
    repeat (3) tick();
    chk("t7_uferr_sticky", {31'd0, underflow_err}, 1);
    wr(16'h7777);
    begin_burst(8'd1);
    sample();
    chk("t7_uferr_cleared", {31'd0, underflow_err}, 0);
    adv();
    run_wait();

    // randomized bursts with random backpressure
    ready_mode = 2;
    for (int k = 0; k < 20; k++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) wr(16'($urandom));
      begin_burst(8'(len));
      run_wait();
      chk($sformatf("t8_words_%0d", k), {24'd0, words_sent}, len);
      chk($sformatf("t8_uferr_%0d", k), {31'd0, underflow_err}, 0);
    end
    chk("t8_all_delivered", del_idx, wr_ptr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side master for the team's synchronous FIFO. Drains a programmed burst of words through the FIFO read port (rd_en, data_out, empty, underflow) and presents them on a valid/ready stream.
- Absorbs the FIFO's one-cycle registered read latency with a 2-entry skid buffer.
- Sits between the FIFO and any downstream consumer. Benches also use it as the reader half of FIFO stimulus.

Parameters:
- FIFO_WIDTH, 16, data width; must match the FIFO.
- LEN_W, 8, width of burst_len and words_sent.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- burst_len  in  LEN_W  number of words to read; sampled with start.
- abort  in  1  stop issuing reads; deliver words already read, then finish.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data_out  in  FIFO_WIDTH  FIFO read data; valid the cycle after rd_en.
- fifo_underflow  in  1  FIFO underflow flag.
- fifo_rd_en  out  1  FIFO read enable.
- m_valid  out  1  stream data valid.
- m_data  out  FIFO_WIDTH  stream data (skid head).
- m_ready  in  1  downstream accept.
- busy  out  1  high in RUN and WAIT.
- done  out  1  one-cycle pulse at burst completion.
- words_sent  out  LEN_W  words delivered (handshakes) in the current or last burst.
- underflow_err  out  1  sticky error flag.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE. fifo_rd_en, m_valid, busy, done, underflow_err=0. m_data=0, words_sent=0. Skid buffer cleared, in-flight flag cleared. Reset mid-burst discards all buffered and in-flight data.
- FSM states are IDLE, RUN, WAIT and DONE.
- IDLE: start=1 latches burst_len, clears words_sent, issued count and underflow_err.
  - burst_len≠0 → RUN.
  - burst_len=0 → DONE.
  - start in any other state is ignored.
- RUN: fifo_rd_en = !fifo_empty && (issued < len) && (occ + inflight − pop ≤ 1).
  - occ is skid occupancy (0..2). inflight is fifo_rd_en registered. pop = m_valid && m_ready.
  - The combinational path m_ready→fifo_rd_en is intentional and gives a sustained rate of one word per cycle.
  - Each fifo_rd_en increments issued.
  - Exit to WAIT when issued reaches len (counting the issuing cycle) or when abort=1. abort suppresses rd_en in the same cycle.
- Capture: when inflight=1, fifo_data_out is written into the skid tail at that edge. Words are delivered FIFO-ordered.
- Stream: m_valid = (occ>0); m_data = head entry. Once m_valid is asserted, m_data holds stable until the handshake.
  - Each handshake increments words_sent; LEN_W arithmetic, no wrap, because words_sent ≤ len.
  - Push and pop in the same cycle leave occ unchanged.
- WAIT: no reads issued. Transition to DONE when occ=0, inflight=0 and no capture is pending. abort in WAIT has no further effect.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in IDLE and DONE.
- Latency: start sampled at edge E0 → fifo_rd_en in cycle 1 (FIFO non-empty) → m_valid in cycle 3.
- Empty FIFO: the reader stalls in RUN indefinitely with fifo_rd_en=0. It never reads while empty.
- Underflow: if fifo_underflow=1 in the cycle after fifo_rd_en, set underflow_err (sticky until the next accepted start). The word is still captured and delivered.
- Backpressure: with m_ready=0, at most 2 words are outstanding (occ + inflight ≤ 2). No data is lost or duplicated.

Test Plan:
- FIFO preloaded with 0x0001..0x0005, burst_len=5, m_ready=1 → fifo_rd_en high cycles 1-5; m_valid cycles 3-7 with data 0x0001..0x0005; done pulse in cycle 9 (WAIT in cycle 8); words_sent=5; underflow_err=0.
- Same preload, m_ready toggling 1,0,1,0… → all 5 words in order, no duplicates; occ+inflight never exceeds 2; m_data stable while m_valid && !m_ready.
- FIFO holds 2 words, burst_len=4 → 2 words delivered, then a stall in RUN with rd_en=0 and busy=1. Writing 2 more words → remaining 2 delivered, done, words_sent=4.
- burst_len=10, abort asserted in cycle 4 (after 3 reads issued) → no rd_en from cycle 4, 3 words delivered, done, words_sent=3, FIFO retains its remaining words.
- Burst in progress with 2 words in skid; rst pulsed asynchronously mid-cycle → outputs 0 immediately, state IDLE. A new start with burst_len=1 works normally.
- burst_len=0 → done the cycle after start, no fifo_rd_en. Also: force fifo_underflow=1 after a read → underflow_err=1, stays 1 until the next start.
